// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the pattern sequencer and its tester-cycle timer.
package pattern_sequencer_pkg;

  localparam int unsigned NUM_PINS = 8;
  localparam int unsigned REP_W    = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LEN_W    = 8;

  localparam logic [LEN_W-1:0] MIN_CYCLE_LEN = LEN_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRIME,
    RUN,
    DONE_ST
  } seq_state_e;

  typedef struct packed {
    logic [NUM_PINS-1:0] d;
    logic [NUM_PINS-1:0] ff;
    logic                tset;
    logic [REP_W-1:0]    rep;
    logic                last;
  } vec_slot_t;

  // Lengths below two cannot hold both a prefetch slot and a boundary tick.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len < MIN_CYCLE_LEN) ? MIN_CYCLE_LEN : len;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Vector stream from the vector memory/FIFO into the sequencer (valid/ready).
interface pattern_sequencer_if;
  import pattern_sequencer_pkg::*;

  logic                VEC_VALID;
  logic                VEC_READY;
  logic [NUM_PINS-1:0] VEC_D;
  logic [NUM_PINS-1:0] VEC_FF;
  logic                VEC_TSET;
  logic [REP_W-1:0]    VEC_REPEAT;
  logic                VEC_LAST;

  modport master (
    output VEC_VALID, VEC_D, VEC_FF, VEC_TSET, VEC_REPEAT, VEC_LAST,
    input  VEC_READY
  );

  modport slave (
    input  VEC_VALID, VEC_D, VEC_FF, VEC_TSET, VEC_REPEAT, VEC_LAST,
    output VEC_READY
  );

endinterface

// File: rtl/pattern_sequencer_tester_cycle_timer.sv
// Counts CLKs within one tester cycle; length is clamped and latched on each restart.
module tester_cycle_timer
  import pattern_sequencer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [LEN_W-1:0] len,
  input  logic             restart,
  input  logic             enable,
  output logic [LEN_W-1:0] count,
  output logic             last_tick
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      len_q   <= MIN_CYCLE_LEN;
    end else if (restart) begin
      count_q <= '0;
      len_q   <= eff_len(len);
    end else if (enable && !last_tick) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count     = count_q;
  assign last_tick = enable && (count_q == len_q - 1'b1);

endmodule

// File: rtl/pattern_sequencer.sv
// Streams test vectors into double-buffered pin channels: LOAD during a tester cycle,
// TRANSFER at its boundary, with repeats and per-vector timing-set selection.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic [LEN_W-1:0]    CYCLE_LENGTH_1,
  input  logic [LEN_W-1:0]    CYCLE_LENGTH_2,
  pattern_sequencer_if.slave  vec,
  output logic                EN_FF_LOGIC,
  output logic                LOAD,
  output logic                TRANSFER,
  output logic [NUM_PINS-1:0] D,
  output logic [NUM_PINS-1:0] FF,
  output logic                TEST_CYCLE,
  output logic                BUSY,
  output logic                DONE,
  output logic                UNDERRUN,
  output logic [CNT_W-1:0]    VEC_COUNT
);

  seq_state_e       state_q, state_d;
  vec_slot_t        pend_q, pend_d, in_slot;
  logic             pend_vld_q, pend_vld_d;
  logic             act_tset_q, act_tset_d;
  logic             act_last_q, act_last_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ready, load, transfer;
  logic             tmr_restart, tmr_last_tick;
  logic [LEN_W-1:0] tmr_len;
  logic [LEN_W-1:0] unused_tmr_count;

  tester_cycle_timer u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .len       (tmr_len),
    .restart   (tmr_restart),
    .enable    (state_q == RUN),
    .count     (unused_tmr_count),
    .last_tick (tmr_last_tick)
  );

  always_comb begin
    in_slot.d    = vec.VEC_D;
    in_slot.ff   = vec.VEC_FF;
    in_slot.tset = vec.VEC_TSET;
    in_slot.rep  = vec.VEC_REPEAT;
    in_slot.last = vec.VEC_LAST;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    act_tset_d  = act_tset_q;
    act_last_d  = act_last_q;
    rep_left_d  = rep_left_q;
    en_d        = en_q;
    done_d      = done_q;
    underrun_d  = underrun_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    transfer    = 1'b0;
    tmr_restart = 1'b0;
    tmr_len     = act_tset_q ? CYCLE_LENGTH_2 : CYCLE_LENGTH_1;

    if (ABORT) begin
      state_d    = IDLE;
      en_d       = 1'b0;
      pend_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            state_d    = FETCH;
            done_d     = 1'b0;
            underrun_d = 1'b0;
            cnt_d      = '0;
          end
        end
        FETCH: begin
          ready = 1'b1;
          if (vec.VEC_VALID) state_d = PRIME;
        end
        PRIME: begin
          transfer = 1'b1;
          state_d  = RUN;
        end
        RUN: begin
          // Prefetch window closes on the boundary tick so LOAD never meets TRANSFER.
          ready = !pend_vld_q && !act_last_q && !tmr_last_tick;
          if (tmr_last_tick) begin
            if (rep_left_q != '0) begin
              rep_left_d  = rep_left_q - 1'b1;
              tmr_restart = 1'b1;
            end else if (pend_vld_q) begin
              transfer = 1'b1;
            end else if (act_last_q) begin
              state_d = DONE_ST;
              en_d    = 1'b0;
            end else begin
              state_d    = IDLE;
              en_d       = 1'b0;
              underrun_d = 1'b1;
            end
          end
        end
        DONE_ST: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (ready && vec.VEC_VALID) begin
        pend_d     = in_slot;
        pend_vld_d = 1'b1;
      end

      if (transfer) begin
        pend_vld_d  = 1'b0;
        act_tset_d  = pend_q.tset;
        act_last_d  = pend_q.last;
        rep_left_d  = pend_q.rep;
        en_d        = 1'b1;
        tmr_restart = 1'b1;
        tmr_len     = pend_q.tset ? CYCLE_LENGTH_2 : CYCLE_LENGTH_1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign load = ready && vec.VEC_VALID;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_tset_q <= 1'b0;
      act_last_q <= 1'b0;
      rep_left_q <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_tset_q <= act_tset_d;
      act_last_q <= act_last_d;
      rep_left_q <= rep_left_d;
      en_q       <= en_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign vec.VEC_READY = ready;
  assign LOAD          = load;
  assign TRANSFER      = transfer;
  // Between loads the bus shows the buffered (pending) vector.
  assign D             = load ? vec.VEC_D : pend_q.d;
  assign FF            = load ? vec.VEC_FF : pend_q.ff;
  assign EN_FF_LOGIC   = en_q;
  assign TEST_CYCLE    = act_tset_q;
  assign BUSY          = (state_q != IDLE);
  assign DONE          = done_q;
  assign UNDERRUN      = underrun_q;
  assign VEC_COUNT     = cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: event log sampled on the falling edge.
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  logic                CLK = 1'b0;
  logic                RST, START, ABORT;
  logic [LEN_W-1:0]    CYCLE_LENGTH_1, CYCLE_LENGTH_2;
  logic                EN_FF_LOGIC, LOAD, TRANSFER, TEST_CYCLE, BUSY, DONE, UNDERRUN;
  logic [NUM_PINS-1:0] D, FF;
  logic [CNT_W-1:0]    VEC_COUNT;

  int checks = 0;
  int errors = 0;

  pattern_sequencer_if vec ();

  pattern_sequencer dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .ABORT          (ABORT),
    .CYCLE_LENGTH_1 (CYCLE_LENGTH_1),
    .CYCLE_LENGTH_2 (CYCLE_LENGTH_2),
    .vec            (vec),
    .EN_FF_LOGIC    (EN_FF_LOGIC),
    .LOAD           (LOAD),
    .TRANSFER       (TRANSFER),
    .D              (D),
    .FF             (FF),
    .TEST_CYCLE     (TEST_CYCLE),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .UNDERRUN       (UNDERRUN),
    .VEC_COUNT      (VEC_COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   load_cyc[$], load_d[$], load_ff[$], tr_cyc[$], tc_after[$];
  int   en_cnt, overlap;
  logic prev_tr;

  always @(negedge CLK) begin
    if (prev_tr) tc_after.push_back(int'(TEST_CYCLE));
    prev_tr = TRANSFER;
    if (LOAD) begin
      load_cyc.push_back(cyc);
      load_d.push_back(int'(D));
      load_ff.push_back(int'(FF));
    end
    if (TRANSFER) tr_cyc.push_back(cyc);
    if (LOAD && TRANSFER) overlap++;
    if (EN_FF_LOGIC) en_cnt++;
  end

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    load_cyc.delete(); load_d.delete(); load_ff.delete(); tr_cyc.delete(); tc_after.delete();
    en_cnt = 0; overlap = 0; prev_tr = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Presents one vector and returns one CLK after the accepting edge.
  task automatic send_vec(input logic [7:0] d, input logic [7:0] ff, input logic tset,
                          input logic [7:0] rep, input logic last);
    bit ok = 1'b0;
    vec.VEC_VALID = 1'b1; vec.VEC_D = d; vec.VEC_FF = ff;
    vec.VEC_TSET = tset; vec.VEC_REPEAT = rep; vec.VEC_LAST = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (vec.VEC_READY) begin ok = 1'b1; break; end
    end
    tick();
    vec.VEC_VALID = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_accept: ready got 0 required 1"); end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!BUSY) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_idle: busy got 1 required 0"); end
  endtask

  task automatic test_reset();
    checks++;
    if ({EN_FF_LOGIC, LOAD, TRANSFER, D, FF, TEST_CYCLE, BUSY, DONE, UNDERRUN, VEC_COUNT,
         vec.VEC_READY} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero required all 0");
    end
  endtask

  task automatic test_single_vector();
    CYCLE_LENGTH_1 = 8'd4;
    clear_log();
    do_start();
    send_vec(8'hA5, 8'hFF, 1'b0, 8'd0, 1'b1);
    wait_idle(50);
    checks++; if (load_cyc.size() != 1) begin errors++;
      $display("FAIL single_loads: got %0d required 1", load_cyc.size()); end
    checks++; if (qi(load_d, 0) != 32'hA5) begin errors++;
      $display("FAIL single_d: got %0h required a5", qi(load_d, 0)); end
    checks++; if (qi(load_ff, 0) != 32'hFF) begin errors++;
      $display("FAIL single_ff: got %0h required ff", qi(load_ff, 0)); end
    checks++; if (tr_cyc.size() != 1 || qi(tr_cyc, 0) != qi(load_cyc, 0) + 1) begin errors++;
      $display("FAIL single_transfer: got %0d transfers required 1 at load+1", tr_cyc.size()); end
    checks++; if (en_cnt != 4) begin errors++;
      $display("FAIL single_en_len: got %0d required 4", en_cnt); end
    checks++; if (DONE !== 1'b1 || VEC_COUNT !== 16'd1) begin errors++;
      $display("FAIL single_done: got done=%b count=%0d required 1/1", DONE, VEC_COUNT); end
  endtask

  task automatic test_back_to_back();
    CYCLE_LENGTH_1 = 8'd5; CYCLE_LENGTH_2 = 8'd8;
    clear_log();
    do_start();
    send_vec(8'h11, 8'h00, 1'b0, 8'd0, 1'b0);
    send_vec(8'h22, 8'h0F, 1'b1, 8'd0, 1'b0);
    send_vec(8'h33, 8'hF0, 1'b0, 8'd0, 1'b1);
    wait_idle(100);
    checks++; if (qi(tr_cyc, 1) - qi(tr_cyc, 0) != 5) begin errors++;
      $display("FAIL b2b_gap1: got %0d required 5", qi(tr_cyc, 1) - qi(tr_cyc, 0)); end
    checks++; if (qi(tr_cyc, 2) - qi(tr_cyc, 1) != 8) begin errors++;
      $display("FAIL b2b_gap2: got %0d required 8", qi(tr_cyc, 2) - qi(tr_cyc, 1)); end
    checks++; if (qi(tc_after, 0) != 0 || qi(tc_after, 1) != 1 || qi(tc_after, 2) != 0) begin
      errors++; $display("FAIL b2b_test_cycle: got %0d%0d%0d required 010",
                         qi(tc_after, 0), qi(tc_after, 1), qi(tc_after, 2)); end
    checks++; if (overlap != 0) begin errors++;
      $display("FAIL b2b_overlap: got %0d required 0", overlap); end
    checks++; if (qi(load_d, 1) != 32'h22 || qi(load_ff, 2) != 32'hF0) begin errors++;
      $display("FAIL b2b_data: got %0h/%0h required 22/f0", qi(load_d, 1), qi(load_ff, 2)); end
    checks++; if (en_cnt != 18 || VEC_COUNT !== 16'd3 || DONE !== 1'b1) begin errors++;
      $display("FAIL b2b_end: got en=%0d count=%0d done=%b required 18/3/1",
               en_cnt, VEC_COUNT, DONE); end
  endtask

  task automatic test_repeat();
    CYCLE_LENGTH_1 = 8'd4;
    clear_log();
    do_start();
    send_vec(8'h5A, 8'h00, 1'b0, 8'd3, 1'b0);
    send_vec(8'h3C, 8'h00, 1'b0, 8'd0, 1'b1);
    wait_idle(100);
    checks++; if (qi(tr_cyc, 1) - qi(tr_cyc, 0) != 16) begin errors++;
      $display("FAIL repeat_gap: got %0d required 16", qi(tr_cyc, 1) - qi(tr_cyc, 0)); end
    checks++; if (tr_cyc.size() != 2 || en_cnt != 20 || VEC_COUNT !== 16'd2) begin errors++;
      $display("FAIL repeat_end: got tr=%0d en=%0d count=%0d required 2/20/2",
               tr_cyc.size(), en_cnt, VEC_COUNT); end
  endtask

  task automatic test_underrun();
    CYCLE_LENGTH_1 = 8'd4;
    clear_log();
    do_start();
    send_vec(8'h01, 8'h00, 1'b0, 8'd0, 1'b0);
    repeat (4) tick();
    vec.VEC_VALID = 1'b1; vec.VEC_LAST = 1'b1;
    @(negedge CLK);
    checks++; if (vec.VEC_READY !== 1'b0) begin errors++;
      $display("FAIL underrun_ready_at_last: got %b required 0", vec.VEC_READY); end
    tick();
    checks++; if (UNDERRUN !== 1'b1 || EN_FF_LOGIC !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0)
    begin errors++; $display("FAIL underrun_state: got u=%b en=%b done=%b busy=%b required 1000",
                             UNDERRUN, EN_FF_LOGIC, DONE, BUSY); end
    vec.VEC_VALID = 1'b0;
    checks++; if (load_cyc.size() != 1 || VEC_COUNT !== 16'd1) begin errors++;
      $display("FAIL underrun_counts: got loads=%0d count=%0d required 1/1",
               load_cyc.size(), VEC_COUNT); end
  endtask

  task automatic test_min_length();
    CYCLE_LENGTH_1 = 8'd0;
    clear_log();
    do_start();
    send_vec(8'h0A, 8'h00, 1'b0, 8'd0, 1'b0);
    send_vec(8'h0B, 8'h00, 1'b0, 8'd0, 1'b0);
    send_vec(8'h0C, 8'h00, 1'b0, 8'd0, 1'b1);
    wait_idle(50);
    checks++; if (qi(tr_cyc, 1) - qi(tr_cyc, 0) != 2 || qi(tr_cyc, 2) - qi(tr_cyc, 1) != 2) begin
      errors++; $display("FAIL minlen_period: got %0d,%0d required 2,2",
                         qi(tr_cyc, 1) - qi(tr_cyc, 0), qi(tr_cyc, 2) - qi(tr_cyc, 1)); end
    checks++; if (qi(load_cyc, 1) != qi(tr_cyc, 0) + 1 || qi(load_cyc, 2) != qi(tr_cyc, 1) + 1)
    begin errors++; $display("FAIL minlen_load_slot: got %0d,%0d required %0d,%0d",
                             qi(load_cyc, 1), qi(load_cyc, 2), qi(tr_cyc, 0) + 1,
                             qi(tr_cyc, 1) + 1); end
    checks++; if (en_cnt != 6 || UNDERRUN !== 1'b0) begin errors++;
      $display("FAIL minlen_end: got en=%0d u=%b required 6/0", en_cnt, UNDERRUN); end
  endtask

  task automatic test_abort_reset();
    CYCLE_LENGTH_1 = 8'd4; CYCLE_LENGTH_2 = 8'd4;
    clear_log();
    do_start();
    send_vec(8'h77, 8'h00, 1'b1, 8'd0, 1'b0);
    repeat (2) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++; if (BUSY !== 1'b0 || EN_FF_LOGIC !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL abort_state: got busy=%b en=%b done=%b required 000",
               BUSY, EN_FF_LOGIC, DONE); end
    do_start();
    send_vec(8'h88, 8'h00, 1'b1, 8'd0, 1'b0);
    repeat (2) tick();
    checks++; if (TEST_CYCLE !== 1'b1 || EN_FF_LOGIC !== 1'b1) begin errors++;
      $display("FAIL prereset_run: got tc=%b en=%b required 11", TEST_CYCLE, EN_FF_LOGIC); end
    #2 RST = 1'b1;
    #1;
    checks++; if ({EN_FF_LOGIC, TEST_CYCLE, BUSY, VEC_COUNT} !== '0) begin errors++;
      $display("FAIL async_reset: got en=%b tc=%b busy=%b count=%0d required all 0",
               EN_FF_LOGIC, TEST_CYCLE, BUSY, VEC_COUNT); end
    @(negedge CLK);
    RST = 1'b0;
    tick();
    clear_log();
    do_start();
    send_vec(8'h99, 8'h00, 1'b0, 8'd0, 1'b1);
    wait_idle(50);
    checks++; if (DONE !== 1'b1 || VEC_COUNT !== 16'd1 || en_cnt != 4) begin errors++;
      $display("FAIL post_reset_run: got done=%b count=%0d en=%0d required 1/1/4",
               DONE, VEC_COUNT, en_cnt); end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    CYCLE_LENGTH_1 = 8'd4; CYCLE_LENGTH_2 = 8'd4;
    vec.VEC_VALID = 1'b0; vec.VEC_D = '0; vec.VEC_FF = '0;
    vec.VEC_TSET = 1'b0; vec.VEC_REPEAT = '0; vec.VEC_LAST = 1'b0;
    clear_log();
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b0;
    tick();
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_repeat();
    test_underrun();
    test_min_length();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
